rc4_decrypt_core: RTL

Consumes the 32-byte ciphertext captured from the encrypted-data ROM and decrypts it with the RC4 PRGA loop, using an externally owned 256×8 S-box RAM that has already been initialised and key-scheduled. Decrypted bytes go to the decrypted-message RAM, and each byte is screened for plaintext validity (lowercase a–z or space). The block reports whether the candidate key produced a valid message. It sits between the ROM reader / KSA stage and the key-search controller.

---
 rtl/rc4_pkg.sv | 26 ++
 rtl/rc4_decrypt_core_if.sv | 37 +++
 rtl/rc4_char_check.sv | 11 +
 rtl/rc4_decrypt_core.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/rc4_pkg.sv
// Shared state encoding and plaintext character bounds for the RC4 key-search cores.
package rc4_pkg;

  localparam int MSG_LEN_DEF = 32;

  localparam logic [7:0] CHAR_LO    = 8'h61;
  localparam logic [7:0] CHAR_HI    = 8'h7A;
  localparam logic [7:0] CHAR_SPACE = 8'h20;

  typedef enum logic [3:0] {
    IDLE,
    RD_I,
    WT_I,
    LD_I,
    RD_J,
    WT_J,
    LD_J,
    WR_I,
    WR_J,
    RD_F,
    WT_F,
    LD_F,
    DONE
  } rc4_state_e;

endpackage

// File: rtl/rc4_decrypt_core_if.sv
// Bundle of request, S-RAM, decrypted-RAM and result signals around rc4_decrypt_core.
interface rc4_decrypt_core_if
  import rc4_pkg::*;
#(
  parameter int MSG_LEN = MSG_LEN_DEF
);
  localparam int K_W = $clog2(MSG_LEN);

  // start is a one-cycle request honoured only while idle; busy covers the whole
  // run including the done cycle, and key_valid holds its result until the next start.
  logic                   start;
  logic [MSG_LEN*8-1:0]   ciphertext;
  logic [7:0]             s_address;
  logic [7:0]             s_data;
  logic                   s_wren;
  logic [7:0]             s_q;
  logic [K_W-1:0]         d_address;
  logic [7:0]             d_data;
  logic                   d_wren;
  logic                   busy;
  logic                   done;
  logic                   key_valid;
  rc4_state_e             state;

  modport master (
    output start, ciphertext, s_q,
    input  s_address, s_data, s_wren, d_address, d_data, d_wren,
           busy, done, key_valid, state
  );

  modport slave (
    input  start, ciphertext, s_q,
    output s_address, s_data, s_wren, d_address, d_data, d_wren,
           busy, done, key_valid, state
  );

endinterface

// File: rtl/rc4_char_check.sv
// Plaintext screen: accepts lowercase letters and space only.
module rc4_char_check
  import rc4_pkg::*;
(
  input  logic [7:0] byte_i,
  output logic       is_valid
);

  assign is_valid = ((byte_i >= CHAR_LO) && (byte_i <= CHAR_HI)) || (byte_i == CHAR_SPACE);

endmodule

// File: rtl/rc4_decrypt_core.sv
// RC4 PRGA decrypt of a captured ciphertext against a pre-scheduled S-box RAM,
// writing plaintext out and flagging whether every byte looks like text.
module rc4_decrypt_core
  import rc4_pkg::*;
#(
  parameter int MSG_LEN     = MSG_LEN_DEF,
  parameter bit EARLY_ABORT = 1'b1
)(
  input  logic               clk,
  input  logic               reset_n,
  rc4_decrypt_core_if.slave  bus
);

  localparam int             K_W  = $clog2(MSG_LEN);
  localparam logic [K_W-1:0] LAST = K_W'(MSG_LEN - 1);

  rc4_state_e     state_q, state_d;
  logic [7:0]     i_q, i_d;
  logic [7:0]     j_q, j_d;
  logic [K_W-1:0] k_q, k_d;
  logic [7:0]     si_q, si_d;
  logic [7:0]     sj_q, sj_d;
  logic           valid_acc_q, valid_acc_d;
  logic           key_valid_q, key_valid_d;

  logic [7:0]     s_address, s_data;
  logic           s_wren;
  logic [K_W-1:0] d_address;
  logic [7:0]     d_data;
  logic           d_wren;
  logic           busy, done;

  logic [7:0]     cipher_byte;
  logic [7:0]     plain;
  logic           plain_ok;

  assign cipher_byte = bus.ciphertext[{k_q, 3'b000} +: 8];
  assign plain       = bus.s_q ^ cipher_byte;

  rc4_char_check u_char_check (
    .byte_i   (plain),
    .is_valid (plain_ok)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      i_q         <= '0;
      j_q         <= '0;
      k_q         <= '0;
      si_q        <= '0;
      sj_q        <= '0;
      valid_acc_q <= 1'b0;
      key_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      i_q         <= i_d;
      j_q         <= j_d;
      k_q         <= k_d;
      si_q        <= si_d;
      sj_q        <= sj_d;
      valid_acc_q <= valid_acc_d;
      key_valid_q <= key_valid_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    i_d         = i_q;
    j_d         = j_q;
    k_d         = k_q;
    si_d        = si_q;
    sj_d        = sj_q;
    valid_acc_d = valid_acc_q;
    key_valid_d = key_valid_q;
    s_address   = '0;
    s_data      = '0;
    s_wren      = 1'b0;
    d_address   = '0;
    d_data      = '0;
    d_wren      = 1'b0;
    busy        = 1'b1;
    done        = 1'b0;

    unique case (state_q)
      IDLE: begin
        busy = 1'b0;
        if (bus.start) begin
          i_d         = '0;
          j_d         = '0;
          k_d         = '0;
          valid_acc_d = 1'b1;
          key_valid_d = 1'b0;
          state_d     = RD_I;
        end
      end
      // The address leads the i register by one so the read and increment share a cycle.
      RD_I: begin
        i_d       = i_q + 8'd1;
        s_address = i_q + 8'd1;
        state_d   = WT_I;
      end
      WT_I: state_d = LD_I;
      LD_I: begin
        si_d    = bus.s_q;
        j_d     = j_q + bus.s_q;
        state_d = RD_J;
      end
      RD_J: begin
        s_address = j_q;
        state_d   = WT_J;
      end
      WT_J: state_d = LD_J;
      LD_J: begin
        sj_d    = bus.s_q;
        state_d = WR_I;
      end
      WR_I: begin
        s_address = i_q;
        s_data    = sj_q;
        s_wren    = 1'b1;
        state_d   = WR_J;
      end
      WR_J: begin
        s_address = j_q;
        s_data    = si_q;
        s_wren    = 1'b1;
        state_d   = RD_F;
      end
      RD_F: begin
        s_address = si_q + sj_q;
        state_d   = WT_F;
      end
      WT_F: state_d = LD_F;
      LD_F: begin
        d_address   = k_q;
        d_data      = plain;
        d_wren      = 1'b1;
        valid_acc_d = valid_acc_q & plain_ok;
        if ((k_q == LAST) || (!plain_ok && EARLY_ABORT)) begin
          state_d = DONE;
        end else begin
          k_d     = k_q + 1'b1;
          state_d = RD_I;
        end
      end
      DONE: begin
        done        = 1'b1;
        key_valid_d = valid_acc_q;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.s_address = s_address;
  assign bus.s_data    = s_data;
  assign bus.s_wren    = s_wren;
  assign bus.d_address = d_address;
  assign bus.d_data    = d_data;
  assign bus.d_wren    = d_wren;
  assign bus.busy      = busy;
  assign bus.done      = done;
  // The verdict is already final in DONE, so present it alongside the done pulse.
  assign bus.key_valid = (state_q == DONE) ? valid_acc_q : key_valid_q;
  assign bus.state     = state_q;

endmodule
